cpu_player: RTL
===============

Name: cpu_player

Overview:
- Computer opponent for the tug-of-war game.
- Generates press pulses on the same interface that a synchronized human key press drives: one-cycle-high, registered, same clock domain.
- Replaces the right-hand player's key synchronizer output at the press-processing stage.
- Press probability per opportunity is set by a 9-bit difficulty value (board: SW[8:0]) compared against a free-running 10-bit LFSR.

Parameters:
- SEED, 10'h000, LFSR reset value; must not be 10'h3FF (the XNOR lock-up state).
- COOLDOWN, 1, forced idle cycles after each press (0..15).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- enable  input  1  CPU player active
- game_over  input  1  victory reached; suppresses presses
- difficulty  input  9  press threshold
- press  output  1  one-cycle press pulse to the press processor
- lfsr_value  output  10  current LFSR state, for debug and HEX display

Behaviour:
- Reset (reset==0 at posedge): lfsr=SEED, state=IDLE, cooldown counter=0, press=0, lfsr_value=SEED. Reset overrides everything, including mid-FIRE or mid-COOL.
- LFSR:
  - Shifts every non-reset cycle: lfsr <= {lfsr[8:0], ~(lfsr[9]^lfsr[6])}.
  - Shifting is independent of enable, game_over and state.
  - Period is 1023 states; 10'h3FF is never reached from a legal seed.
- hit = enable & ~game_over & ({1'b0,difficulty} > lfsr). The comparison is unsigned, 10-bit, and uses the current (pre-shift) lfsr.
- States: IDLE, ARMED, FIRE, COOL.
- Transition priority: reset, then (~enable | game_over) → IDLE from any state, then the per-state rules:
  - IDLE → ARMED when enable & ~game_over.
  - ARMED → FIRE on hit; otherwise stay in ARMED.
  - FIRE → COOL, loading the counter with COOLDOWN-1, if COOLDOWN>0. If COOLDOWN==0, FIRE → ARMED.
  - COOL → ARMED when counter==0; otherwise decrement the counter.
- press = (state==FIRE). It is a registered output and is high for exactly one cycle per FIRE entry.
- Latency: hit evaluated in ARMED at cycle n gives press high during cycle n+1.
- Minimum spacing: press pulses are separated by at least COOLDOWN+1 low cycles. Maximum rate is one press per COOLDOWN+2 cycles.
- Boundary conditions:
  - difficulty==0: hit is never true and press stays 0.
  - difficulty==511: hit when lfsr<511, which is 511 of the 1023 states.
  - game_over asserted during FIRE: the pulse still ends after its single cycle, then the FSM goes to IDLE. No further presses occur until game_over deasserts.
  - enable deasserted during COOL: the cooldown is abandoned and the FSM goes to IDLE. On re-enable the FSM passes IDLE → ARMED, a 1-cycle delay.
- lfsr_value = lfsr, combinational from the register.

Optional Feature:
- Macro: CPU_PLAYER_PRESS_COUNT_EN.
- When defined:
  - Adds output press_count[7:0].
  - Reset value 0.
  - Increments on every cycle press==1.
  - Saturates at 8'hFF with no wrap.
  - Cleared to 0 on the cycle game_over rises (registered edge detect).
- When undefined: the port, counter and edge-detect register are absent, and all other behaviour is identical.

Test Plan:
- Reset, SEED=0, difficulty=0, enable=1 for 2100 cycles → press never 1. lfsr_value sequence after reset: 0,1,3,7,15,31,63,127,254,508,1016; never 10'h3FF.
- Reset, difficulty=2, enable=1, COOLDOWN=1 → after edge 1 state ARMED with lfsr=1; press high only during the cycle after edge 2; press 0 for cycles 3–12.
- difficulty=511, enable=1, 5000 cycles → every press pulse is exactly 1 cycle wide and every gap is ≥2 low cycles. Press count is between 1/3 and 1/12 of cycles.
- difficulty=511, assert game_over the cycle press rises → press falls next cycle and stays 0 for 100 cycles. Deassert game_over → presses resume; the first press comes no earlier than 2 cycles later.
- Drive reset=0 during FIRE, then release → press=0 the cycle after the reset edge, and lfsr_value=SEED.
- With CPU_PLAYER_PRESS_COUNT_EN: 300 presses → press_count==8'hFF; game_over rise → press_count==0 next cycle.

Source files
------------

// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war: LFSR-driven press pulses gated by a difficulty threshold.
// Optional press counter enabled by defining CPU_PLAYER_PRESS_COUNT_EN.
module cpu_player #(
    parameter logic [9:0]  SEED     = 10'h000,
    parameter int unsigned COOLDOWN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       game_over,
    input  logic [8:0] difficulty,
    output logic       press,
    output logic [9:0] lfsr_value
`ifdef CPU_PLAYER_PRESS_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    typedef enum logic [1:0] {StIdle, StArmed, StFire, StCool} state_e;

    localparam logic [3:0] CoolLoad = 4'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    state_e     state_q;
    logic [9:0] lfsr_q;
    logic [3:0] cnt_q;
    logic       press_q;
    logic       hit;

    // Compare against the pre-shift LFSR value.
    assign hit        = enable & ~game_over & ({1'b0, difficulty} > lfsr_q);
    assign press      = press_q;
    assign lfsr_value = lfsr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q  <= SEED;
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            press_q <= 1'b0;
        end else begin
            lfsr_q  <= {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};
            press_q <= 1'b0;
            if (!enable || game_over) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle:  state_q <= StArmed;
                    StArmed: begin
                        if (hit) begin
                            state_q <= StFire;
                            press_q <= 1'b1;
                        end
                    end
                    StFire: begin
                        if (COOLDOWN > 0) begin
                            state_q <= StCool;
                            cnt_q   <= CoolLoad;
                        end else begin
                            state_q <= StArmed;
                        end
                    end
                    StCool: begin
                        if (cnt_q == 4'd0) state_q <= StArmed;
                        else               cnt_q   <= cnt_q - 4'd1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef CPU_PLAYER_PRESS_COUNT_EN
    logic [7:0] press_count_q;
    logic       game_over_q;

    assign press_count = press_count_q;

    // Clear on the rising edge of game_over takes priority over counting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            press_count_q <= 8'd0;
            game_over_q   <= 1'b0;
        end else begin
            game_over_q <= game_over;
            if (game_over && !game_over_q)              press_count_q <= 8'd0;
            else if (press_q && press_count_q != 8'hFF) press_count_q <= press_count_q + 8'd1;
        end
    end
`endif

endmodule
